// File: rtl/addsub_pkg.sv
// Shared encodings and defaults for the add/sub display controller.
package addsub_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   localparam int LED_CARRY = 0;
   localparam int LED_OVF   = 1;
   localparam int LED_ZERO  = 2;
   localparam int LED_MODE  = 3;

   localparam int DEF_W         = 8;
   localparam int DEF_DB_CYCLES = 16;

endpackage

// File: rtl/addsub_display_ctrl_btn_cond.sv
// One button: 2-flop sync, optional debounce, rising-edge pulse.
// Debounce is built only when ADDSUB_DEBOUNCE_EN is defined.
module btn_cond
   import addsub_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_pulse
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic       r_armed;
   logic [1:0] r_vld;
   logic       w_level;

   // Pulses stay blocked until a released level is seen after reset,
   // so a button held through reset cannot fire on release of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
         r_vld   <= 2'b00;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= w_level;
         r_vld   <= {r_vld[0], 1'b1};
         r_armed <= r_armed | (r_vld[1] & ~r_sync2);
      end
   end

`ifdef ADDSUB_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES);

   logic [CW-1:0] r_cnt;
   logic          r_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (r_sync2 != r_level) begin
         if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end else begin
         r_cnt <= '0;
      end
   end

   assign w_level = r_level;
`else
   assign w_level = r_sync2;
`endif

   assign o_pulse = w_level & ~r_prev & r_armed;

endmodule

// File: rtl/addsub_display_ctrl.sv
// Nibble-loaded add/subtract unit with paged 4-bit LED display.
// Optional button debounce: define ADDSUB_DEBOUNCE_EN.
module addsub_display_ctrl
   import addsub_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sw,
   input  logic [3:0] btn,
   output logic [3:0] led
);

   localparam int NP = W / 4;
   localparam int PW = $clog2(NP + 1);

   logic [3:0]    w_press;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_sum;
   logic          r_carry;
   logic          r_ovf;
   logic          r_zero;
   mode_e         r_mode;
   logic [PW-1:0] r_page;

   logic [W-1:0]  w_bx;
   logic [W:0]    w_full;
   logic          w_sub;
   logic          w_ovf;
   logic [W-1:0]  w_shift_in;
   logic [3:0]    w_nib;
   logic          w_flags_pg;

   for (genvar g = 0; g < 4; g++) begin : g_btn
      btn_cond #(
         .DB_CYCLES(DB_CYCLES)
      ) u_btn (
         .clk    (clk),
         .reset  (reset),
         .i_btn  (btn[g]),
         .o_pulse(w_press[g])
      );
   end

   assign w_sub  = (r_mode == MODE_SUB);
   assign w_bx   = w_sub ? ~r_b : r_b;
   assign w_full = {1'b0, r_a} + {1'b0, w_bx} + (W+1)'(w_sub);
   assign w_ovf  = (r_a[W-1] == w_bx[W-1])
                 & (w_full[W-1] != r_a[W-1]);

   // Keeping the low W bits of {reg, sw} is the nibble shift-in,
   // and degenerates to plain sw when W is 4.
   assign w_shift_in = W'({r_a, sw});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         if (w_press[0]) r_a <= w_shift_in;
         if (w_press[1]) r_b <= W'({r_b, sw});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode <= MODE_ADD;
         r_page <= '0;
      end else begin
         if (w_press[3])
            r_mode <= w_sub ? MODE_ADD : MODE_SUB;
         if (w_press[2])
            r_page <= (r_page == PW'(NP)) ? '0 : r_page + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b1;
      end else begin
         r_sum   <= w_full[W-1:0];
         r_carry <= w_full[W];
         r_ovf   <= w_ovf;
         r_zero  <= (w_full[W-1:0] == '0);
      end
   end

   assign w_flags_pg = (r_page == PW'(NP));
   assign w_nib      = 4'(r_sum >> {r_page, 2'b00});

   always_comb begin
      led = w_nib;
      if (w_flags_pg) begin
         led            = '0;
         led[LED_MODE]  = w_sub;
         led[LED_ZERO]  = r_zero;
         led[LED_OVF]   = r_ovf;
         led[LED_CARRY] = r_carry;
      end
   end

endmodule

// File: tb/tb_addsub_display_ctrl.sv
// Scoreboard bench: stimulus queues expected led values,
// a negedge monitor pops and compares them.
module tb_addsub_display_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] sw;
   logic [3:0] btn;
   logic [3:0] led;

   typedef struct {
      string      name;
      logic [3:0] val;
   } sb_t;

   sb_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   addsub_display_ctrl #(
      .W        (8),
      .DB_CYCLES(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .sw   (sw),
      .btn  (btn),
      .led  (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         sb_t e;
         e = exp_q.pop_front();
         checks++;
         if (led !== e.val) begin
            errors++;
            $display("FAIL %s: led=%b expected %b",
                     e.name, led, e.val);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [3:0] v);
      sb_t e;
      e.name = n;
      e.val  = v;
      exp_q.push_back(e);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++)
         @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: monitor timeout, expected %b", n, v);
         exp_q.delete();
      end
      #1;
   endtask

   task automatic press(input logic [3:0] m, input int hold);
      btn = m;
      cyc(hold);
      btn = 4'h0;
      cyc(14);
   endtask

   task automatic ld(input logic [3:0] m, input logic [3:0] v);
      sw = v;
      press(m, 10);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(4);
   endtask

   initial begin
      reset = 1'b1;
      sw    = 4'h0;
      btn   = 4'h0;
      #1;
      cyc(3);
      reset = 1'b0;
      cyc(4);

      chk("reset_pg0", 4'b0000);
      press(4'b0100, 10);
      press(4'b0100, 10);
      chk("reset_flags", 4'b0100);
      press(4'b0100, 10);
      chk("wrap_pg0", 4'b0000);

      // A=0x7F, B=0x01 in add mode
      ld(4'b0001, 4'h7);
      ld(4'b0001, 4'hF);
      chk("a7f_pg0", 4'hF);
      ld(4'b0010, 4'h0);
      ld(4'b0010, 4'h1);
      chk("add_pg0", 4'b0000);
      press(4'b0100, 10);
      chk("add_pg1", 4'b1000);
      press(4'b0100, 10);
      chk("add_flags", 4'b0010);
      press(4'b0100, 10);

      // A=0x05, B=0x07, then subtract
      ld(4'b0001, 4'h0);
      ld(4'b0001, 4'h5);
      ld(4'b0010, 4'h0);
      ld(4'b0010, 4'h7);
      chk("add57_pg0", 4'hC);
      press(4'b1000, 10);
      chk("sub_pg0", 4'b1110);
      press(4'b0100, 10);
      chk("sub_pg1", 4'b1111);
      press(4'b0100, 10);
      chk("sub_flags", 4'b1000);

      // A=B=0x3C via simultaneous loads
      ld(4'b0011, 4'h3);
      ld(4'b0011, 4'hC);
      chk("sub_eq_flags", 4'b1101);
      press(4'b1100, 10);
      chk("pg_mode_pg0", 4'h8);
      press(4'b0100, 10);
      chk("add3c_pg1", 4'h7);

      // Page sequence from reset, then a long hold
      do_reset();
      ld(4'b0001, 4'h2);
      ld(4'b0001, 4'h1);
      chk("seq_pg0", 4'h1);
      press(4'b0100, 10);
      chk("seq_pg1", 4'h2);
      press(4'b0100, 10);
      chk("seq_flags", 4'b0000);
      press(4'b0100, 10);
      chk("seq_wrap", 4'h1);
      press(4'b0100, 50);
      chk("hold_once", 4'h2);

      // Reset while btn0 is held
      sw  = 4'h5;
      btn = 4'b0001;
      cyc(1);
      reset = 1'b1;
      chk("rst_imm", 4'b0000);
      cyc(2);
      reset = 1'b0;
      cyc(20);
      chk("rst_held", 4'b0000);
      btn = 4'b0000;
      cyc(14);
      chk("rst_release", 4'b0000);
      press(4'b0001, 10);
      chk("rst_repress", 4'h5);

`ifdef ADDSUB_DEBOUNCE_EN
      sw = 4'h9;
      press(4'b0001, 3);
      chk("db_short", 4'h5);
      press(4'b0001, 6);
      chk("db_long_pg0", 4'h9);
      press(4'b0100, 10);
      chk("db_long_pg1", 4'h5);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/addsub_display_ctrl.md
ADDSUB_DISPLAY_CTRL -- requirements
Module: addsub_display_ctrl

Interface
REQ-001 Parameter W, default 8: operand/result width; SHALL be a multiple of 4 in range 4..16.
REQ-002 Parameter DB_CYCLES, default 16: debounce stability count; SHALL be at least 2.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port sw, input, 4: nibble data source for operand loading.
REQ-006 Port btn, input, 4: raw buttons; btn0 load A, btn1 load B, btn2 next display page, btn3 toggle add/sub mode.
REQ-007 Port led, output, 4: current display page.

Function
REQ-008 Each btn bit SHALL pass through a 2-flop synchroniser, then conditioning (REQ-025/026), then a rising-edge detector giving a one-cycle press pulse.
REQ-009 A held button SHALL produce exactly one pulse per press.
REQ-010 On an A pulse, A SHALL become {A[W-5:0], sw} (nibble shift-in from the right); for W=4, A SHALL become sw. B behaves the same on a B pulse.
REQ-011 Simultaneous A and B pulses SHALL load the same sw into both operands.
REQ-012 A mode pulse SHALL toggle mode (0 = add, 1 = subtract).
REQ-013 Result register SHALL capture, one cycle after any operand or mode change, sum = A + B (add) or A + ~B + 1 (subtract), truncated to W bits.
REQ-014 carry SHALL be bit W of that (W+1)-bit sum; in subtract mode carry = 1 means no borrow.
REQ-015 ovf SHALL be the signed two's-complement overflow: the operands' effective sign bits are equal and differ from sum[W-1].
REQ-016 zero SHALL be 1 when sum equals 0.
REQ-017 Page counter SHALL run 0..W/4; a page pulse SHALL increment it, wrapping from W/4 back to 0.
REQ-018 Page p < W/4: led SHALL show sum[4p+3:4p].
REQ-019 Page W/4 (flags page): led SHALL be {mode, zero, ovf, carry} (led0 = carry).
REQ-020 led SHALL be combinational from the page counter and the registered result/mode; a press pulse in cycle t SHALL be visible on led in cycle t+2.
REQ-021 Page and mode pulses in the same cycle SHALL both take effect.

Reset
REQ-022 Reset assertion SHALL immediately clear A, B, result, carry, ovf, mode and page to 0, set zero to 1, and clear all synchroniser, debounce and edge-detector state; led SHALL then read 0000.
REQ-023 A press in progress when reset asserts SHALL be discarded; a button still held when reset releases SHALL NOT generate a pulse until it is released and pressed again.
REQ-024 Reset deassertion SHALL be safe for all state, with the first update on the next clk rising edge.

Configuration
REQ-025 With macro ADDSUB_DEBOUNCE_EN defined: the conditioned level SHALL change only after the synchronised input differs from it for DB_CYCLES consecutive cycles; any mismatch-free cycle SHALL restart the count.
REQ-026 Without ADDSUB_DEBOUNCE_EN: the conditioned level SHALL equal the synchronised input, DB_CYCLES SHALL be ignored, and no counter logic SHALL be generated.

Structure
REQ-027 Shared package addsub_pkg SHALL hold the mode encoding (MODE_ADD, MODE_SUB), the flags-page LED bit positions, and default values for W and DB_CYCLES.
REQ-028 Sub-module btn_cond SHALL implement synchroniser, optional debounce and edge detection for one button, instantiated four times.

Verification
REQ-029 Debounce disabled, W=8: load A (sw=7 then F, btn0), load B (sw=0 then 1, btn1) -> page0 led=0000, page1 led=1000, flags page led=0010 (ovf=1, carry=0).
REQ-030 Subtract mode, A=0x05, B=0x07 -> sum 0xFE, pages 1110/1111, flags led=1000 (mode=1, zero=0, ovf=0, carry=0).
REQ-031 Subtract mode, A=B=0x3C -> sum 0x00, flags led=1101 (zero=1, carry=1).
REQ-032 W=8: three page presses from reset -> pages 1, 2, 0; btn2 held 50 cycles -> exactly one increment.
REQ-033 Debounce enabled, DB_CYCLES=4: btn0 high 3 cycles -> no load; high 6 cycles -> exactly one load.
REQ-034 Reset asserted mid-load while btn0 held -> led=0000 immediately; no load after release until btn0 is pressed again.
